// File: rtl/vtg_pkg.sv
// vtg_pkg: shared types and constants for the video timing / test-pattern
// generator.
//   pattern_e  - run-time pattern select encoding.
//   vtiming_t  - vertical timing set (VACT, VS_START, VS_END, VTOTAL).
//   vtiming()  - returns the vertical timing for a pal/scandouble mode.
//   LFSR_SEED / LFSR_TAPS - dither source constants (used with VTG_DITHER_EN).
package vtg_pkg;

  typedef enum logic [1:0] {
    PAT_BLACK   = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_HRAMP   = 2'd2,
    PAT_VSCROLL = 2'd3
  } pattern_e;

  // Wide enough for the doubled PAL line count (624).
  localparam int VC_W = 11;

  typedef struct packed {
    logic [VC_W-1:0] vact;
    logic [VC_W-1:0] vs_start;
    logic [VC_W-1:0] vs_end;
    logic [VC_W-1:0] vtotal;
  } vtiming_t;

  localparam logic [VC_W-1:0] NTSC_VACT     = 11'd240;
  localparam logic [VC_W-1:0] NTSC_VS_START = 11'd245;
  localparam logic [VC_W-1:0] NTSC_VS_END   = 11'd248;
  localparam logic [VC_W-1:0] NTSC_VTOTAL   = 11'd262;
  localparam logic [VC_W-1:0] PAL_VACT      = 11'd300;
  localparam logic [VC_W-1:0] PAL_VS_START  = 11'd304;
  localparam logic [VC_W-1:0] PAL_VS_END    = 11'd308;
  localparam logic [VC_W-1:0] PAL_VTOTAL    = 11'd312;

  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic vtiming_t vtiming(input logic pal, input logic sd);
    vtiming_t t;
    if (pal) begin
      t.vact     = PAL_VACT;
      t.vs_start = PAL_VS_START;
      t.vs_end   = PAL_VS_END;
      t.vtotal   = PAL_VTOTAL;
    end else begin
      t.vact     = NTSC_VACT;
      t.vs_start = NTSC_VS_START;
      t.vs_end   = NTSC_VS_END;
      t.vtotal   = NTSC_VTOTAL;
    end
    // Scandoubling draws every source line twice.
    if (sd) begin
      t.vact     = t.vact << 1;
      t.vs_start = t.vs_start << 1;
      t.vs_end   = t.vs_end << 1;
      t.vtotal   = t.vtotal << 1;
    end
    return t;
  endfunction

endpackage

// File: rtl/vtg_lfsr.sv
// vtg_lfsr: 16-bit Fibonacci LFSR used as the dither source.
//   clk, reset - clock and synchronous active-high reset (loads LFSR_SEED).
//   i_step     - advance one step (driven by the pixel enable).
//   o_dither   - low two bits of the LFSR state.
module vtg_lfsr
  import vtg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_step,
  output logic [1:0] o_dither
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb     = ^(r_lfsr & LFSR_TAPS);
  assign o_dither = r_lfsr[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_step) begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

endmodule

// File: rtl/vtg_pattern_gen.sv
// vtg_pattern_gen: raster timing and test-pattern source (NTSC/PAL, optional
// scandoubling, four patterns).
//   clk, reset    - clock, synchronous active-high reset.
//   pal           - 1 = PAL vertical timing, 0 = NTSC.
//   scandouble    - 1 = doubled line count, pixel enable every clk.
//   pattern_sel   - 0 black, 1 bars, 2 horizontal ramp, 3 scrolling ramp.
//   ce_pix        - pixel enable.
//   hblank/hsync/vblank/vsync - raster strobes, active-high.
//   frame_cnt     - completed frame count (wraps).
//   video         - pixel value.
// Optional build macro VTG_DITHER_EN: subtract an LFSR dither (saturating at
// 0) from active pixels.
// Strobes and video are registered on pixel-enable cycles from the counter
// values before they advance, so they lag hc/vc by one pixel. Mode inputs
// are sampled during reset and at each frame wrap only.
module vtg_pattern_gen
  import vtg_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int HTOTAL    = 638,
  parameter int HACT      = 529,
  parameter int HS_START  = 544,
  parameter int HS_END    = 590,
  parameter int BAR_SHIFT = 6,
  parameter int FRAME_W   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pal,
  input  logic               scandouble,
  input  logic [1:0]         pattern_sel,
  output logic               ce_pix,
  output logic               hblank,
  output logic               hsync,
  output logic               vblank,
  output logic               vsync,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic [DATA_W-1:0]  video
);

  localparam int HC_W = $clog2(HTOTAL);
  // hc view wide enough for both the ramp and the bar-index slice.
  localparam int HX_W = (DATA_W > BAR_SHIFT + 3) ? DATA_W : BAR_SHIFT + 3;

  logic               r_ce;
  logic [HC_W-1:0]    r_hc;
  logic [VC_W-1:0]    r_vc;
  logic [FRAME_W-1:0] r_frame;
  logic               r_pal;
  logic               r_sd;
  pattern_e           r_sel;
  logic               r_hblank, r_hsync, r_vblank, r_vsync;
  logic [DATA_W-1:0]  r_video;

  vtiming_t           w_vt;
  logic               w_h_last, w_v_last, w_wrap, w_sd_nxt;
  logic               w_hblank, w_hsync, w_vblank, w_vsync;
  logic [HX_W-1:0]    w_hx;
  logic [VC_W-1:0]    w_vl;
  logic [DATA_W-1:0]  w_pattern;
  logic [DATA_W-1:0]  w_pix;

  assign w_vt     = vtiming(r_pal, r_sd);
  assign w_h_last = (r_hc == HC_W'(HTOTAL - 1));
  assign w_v_last = (r_vc == w_vt.vtotal - VC_W'(1));
  assign w_wrap   = r_ce & w_h_last & w_v_last;
  // The new rate applies from the cycle right after the frame wrap.
  assign w_sd_nxt = w_wrap ? scandouble : r_sd;

  assign w_hblank = (r_hc >= HC_W'(HACT));
  assign w_hsync  = (r_hc >= HC_W'(HS_START)) && (r_hc < HC_W'(HS_END));
  assign w_vblank = (r_vc >= w_vt.vact);
  assign w_vsync  = (r_vc >= w_vt.vs_start) && (r_vc < w_vt.vs_end);

  assign w_hx = HX_W'(r_hc);
  assign w_vl = r_sd ? (r_vc >> 1) : r_vc;

  always_comb begin
    w_pattern = '0;
    case (r_sel)
      PAT_BLACK:   w_pattern = '0;
      PAT_BARS:    w_pattern = {w_hx[BAR_SHIFT+2:BAR_SHIFT], {(DATA_W-3){1'b0}}};
      PAT_HRAMP:   w_pattern = w_hx[DATA_W-1:0];
      PAT_VSCROLL: w_pattern = DATA_W'(32'(w_vl) + 32'(r_frame));
    endcase
  end

`ifdef VTG_DITHER_EN
  logic [1:0] w_dither;

  vtg_lfsr u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .i_step   (r_ce),
    .o_dither (w_dither)
  );

  assign w_pix = (w_pattern >= DATA_W'(w_dither)) ? (w_pattern - DATA_W'(w_dither)) : '0;
`else
  assign w_pix = w_pattern;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ce     <= 1'b0;
      r_hc     <= '0;
      r_vc     <= '0;
      r_frame  <= '0;
      r_pal    <= pal;
      r_sd     <= scandouble;
      r_sel    <= pattern_e'(pattern_sel);
      r_hblank <= 1'b0;
      r_hsync  <= 1'b0;
      r_vblank <= 1'b0;
      r_vsync  <= 1'b0;
      r_video  <= '0;
    end else begin
      r_ce <= w_sd_nxt ? 1'b1 : ~r_ce;
      if (r_ce) begin
        r_hblank <= w_hblank;
        r_hsync  <= w_hsync;
        r_vblank <= w_vblank;
        r_vsync  <= w_vsync;
        r_video  <= (w_hblank | w_vblank) ? '0 : w_pix;
        if (w_h_last) begin
          r_hc <= '0;
          if (w_v_last) begin
            r_vc    <= '0;
            r_frame <= r_frame + FRAME_W'(1);
            r_pal   <= pal;
            r_sd    <= scandouble;
            r_sel   <= pattern_e'(pattern_sel);
          end else begin
            r_vc <= r_vc + VC_W'(1);
          end
        end else begin
          r_hc <= r_hc + HC_W'(1);
        end
      end
    end
  end

  assign ce_pix    = r_ce;
  assign hblank    = r_hblank;
  assign hsync     = r_hsync;
  assign vblank    = r_vblank;
  assign vsync     = r_vsync;
  assign frame_cnt = r_frame;
  assign video     = r_video;

endmodule

// File: tb/tb_vtg_pattern_gen.sv
// tb_vtg_pattern_gen: bench for vtg_pattern_gen with a short line (HTOTAL=12)
// so that several whole frames fit in a short run. A pixel-index model
// predicts every output each cycle; directed literal checks pin timing.
module tb_vtg_pattern_gen;

  localparam int DATA_W    = 8;
  localparam int HTOTAL    = 12;
  localparam int HACT      = 8;
  localparam int HS_START  = 9;
  localparam int HS_END    = 11;
  localparam int BAR_SHIFT = 1;
  localparam int FRAME_W   = 10;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               pal = 1'b0;
  logic               scandouble = 1'b0;
  logic [1:0]         pattern_sel = 2'd0;
  logic               ce_pix, hblank, hsync, vblank, vsync;
  logic [FRAME_W-1:0] frame_cnt;
  logic [DATA_W-1:0]  video;

  vtg_pattern_gen #(
    .DATA_W(DATA_W), .HTOTAL(HTOTAL), .HACT(HACT), .HS_START(HS_START),
    .HS_END(HS_END), .BAR_SHIFT(BAR_SHIFT), .FRAME_W(FRAME_W)
  ) dut (
    .clk(clk), .reset(reset), .pal(pal), .scandouble(scandouble),
    .pattern_sel(pattern_sel), .ce_pix(ce_pix), .hblank(hblank),
    .hsync(hsync), .vblank(vblank), .vsync(vsync), .frame_cnt(frame_cnt),
    .video(video)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard counters ----------------
  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The raster is tracked as a pixel index within the frame; hc/vc are
  // derived from it by division.
  bit          m_ce, m_pal, m_sd;
  int          m_sel, m_pos, m_frame;
  int          m_oh = -1, m_ov = -1, m_of = -1;
  int          e_hb, e_hs, e_vb, e_vs, e_vid;
  logic [15:0] m_lfsr;

  always @(posedge clk) begin : model
    int h, v, vact, vss, vse, vtot, pat, d;
    if (reset) begin
      m_ce = 0; m_pos = 0; m_frame = 0;
      m_pal = pal; m_sd = scandouble; m_sel = int'(pattern_sel);
      e_hb = 0; e_hs = 0; e_vb = 0; e_vs = 0; e_vid = 0;
      m_oh = -1; m_ov = -1; m_of = -1;
      m_lfsr = 16'hACE1;
    end else begin
      if (m_ce) begin
        vact = (m_pal ? 300 : 240) * (m_sd ? 2 : 1);
        vss  = (m_pal ? 304 : 245) * (m_sd ? 2 : 1);
        vse  = (m_pal ? 308 : 248) * (m_sd ? 2 : 1);
        vtot = (m_pal ? 312 : 262) * (m_sd ? 2 : 1);
        h = m_pos % HTOTAL;
        v = m_pos / HTOTAL;
        e_hb = (h >= HACT) ? 1 : 0;
        e_hs = (h >= HS_START && h < HS_END) ? 1 : 0;
        e_vb = (v >= vact) ? 1 : 0;
        e_vs = (v >= vss && v < vse) ? 1 : 0;
        case (m_sel)
          1:       pat = ((h / (1 << BAR_SHIFT)) % 8) * (1 << (DATA_W - 3));
          2:       pat = h % (1 << DATA_W);
          3:       pat = ((v / (m_sd ? 2 : 1)) + m_frame) % (1 << DATA_W);
          default: pat = 0;
        endcase
`ifdef VTG_DITHER_EN
        d = int'(m_lfsr % 4);
        pat = (pat >= d) ? pat - d : 0;
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`else
        d = 0;
`endif
        e_vid = (e_hb != 0 || e_vb != 0) ? 0 : pat;
        m_oh = h; m_ov = v; m_of = m_frame;
        m_pos++;
        if (m_pos == HTOTAL * vtot) begin
          m_pos = 0;
          m_frame = (m_frame + 1) % (1 << FRAME_W);
          m_pal = pal; m_sd = scandouble; m_sel = int'(pattern_sel);
        end
      end
      m_ce = m_sd ? 1'b1 : ~m_ce;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("ce_pix",    ce_pix,    m_ce);
      check("hblank",    hblank,    e_hb);
      check("hsync",     hsync,     e_hs);
      check("vblank",    vblank,    e_vb);
      check("vsync",     vsync,     e_vs);
      check("frame_cnt", frame_cnt, m_frame);
      check("video",     video,     e_vid);
    end
  end

  // ---------------- edge monitor (in clk cycles) ----------------
  int hs_rise = -1, hs_period = -1, hs_width = -1;
  int vs_rise = -1, vs_width = -1, vb_rise = -1;
  int fr_edge = -1, fr_len = -1, ce_lo = 0;
  logic p_hs = 0, p_vs = 0, p_vb = 0;
  int p_fc = 0;

  always @(negedge clk) begin
    if (hsync === 1'b1 && p_hs === 1'b0) begin hs_period = cyc - hs_rise; hs_rise = cyc; end
    if (hsync === 1'b0 && p_hs === 1'b1) hs_width = cyc - hs_rise;
    if (vsync === 1'b1 && p_vs === 1'b0) vs_rise = cyc;
    if (vsync === 1'b0 && p_vs === 1'b1) vs_width = cyc - vs_rise;
    if (vblank === 1'b1 && p_vb === 1'b0) vb_rise = cyc;
    if (int'(frame_cnt) != p_fc) begin fr_len = cyc - fr_edge; fr_edge = cyc; end
    if (ce_pix !== 1'b1) ce_lo++;
    p_hs = hsync; p_vs = vsync; p_vb = vblank; p_fc = int'(frame_cnt);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_frame(input int f, input int budget);
    int n = 0;
    while (m_frame != f && n < budget) begin step(); n++; end
    check("wait_frame_timeout", m_frame, f);
  endtask

  task automatic wait_out(input int f, input int v, input int h, input int budget);
    int n = 0;
    while (!(m_of == f && m_ov == v && m_oh == h) && n < budget) begin step(); n++; end
    check("wait_out_timeout", n < budget, 1);
  endtask

  // ---------------- directed sequence ----------------
  int f7, a;

  initial begin
    reset = 1'b1; pal = 1'b0; scandouble = 1'b0; pattern_sel = 2'd0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) step();
    check("rst_ce",     ce_pix, 0);
    check("rst_hblank", hblank, 0);
    check("rst_hsync",  hsync, 0);
    check("rst_vblank", vblank, 0);
    check("rst_vsync",  vsync, 0);
    check("rst_frame",  frame_cnt, 0);
    check("rst_video",  video, 0);
    reset = 1'b0;
    step();
    check("first_ce", ce_pix, 1);

    // NTSC, not doubled: line = 2*12 clk, hsync 2 px, vsync 3 lines.
    wait_out(0, 5, 3, 1000);
    check("black_active", video, 0);
    wait_frame(1, 7000);
    check("hs_period", hs_period, 24);
    check("hs_width",  hs_width, 4);
    check("vs_width",  vs_width, 72);
    pattern_sel = 2'd3;
    wait_frame(2, 7000);
    check("ntsc_frame_len", fr_len, 6288);   // 262 lines * 24 clk

    // Scrolling ramp: frame 5, line 10 -> 10 + 5 = 15.
    wait_out(5, 10, 0, 25000);
    check("p3_first_px", video, 15);
    check("p3_frame",    frame_cnt, 5);
    wait_out(5, 10, HACT, 100);
    check("p3_hact_video",  video, 0);
    check("p3_hact_hblank", hblank, 1);

    // Mode change mid-frame: old VTOTAL until the wrap.
    wait_out(5, 100, 0, 5000);
    pal = 1'b1;
    pattern_sel = 2'd1;
    wait_frame(6, 5000);
    check("old_vtotal_len", fr_len, 6288);
    check("frame_once",     frame_cnt, 6);
    wait_out(6, 0, 4, 100);
`ifndef VTG_DITHER_EN
    check("bars_h4", video, 64);             // (4>>1)=2 in the top 3 bits
`endif
    scandouble = 1'b1;
    wait_frame(7, 8000);
    check("pal_frame_len", fr_len, 7488);    // 312 lines * 24 clk
    f7 = fr_edge;
    ce_lo = 0;

    // PAL doubled: 624 lines of 12 clk, pixel p visible at wrap+1+p.
    wait_frame(8, 8000);
    check("sd_ce_const",    ce_lo, 0);
    check("sd_frame_len",   fr_len, 7488);
    check("vblank_line600", vb_rise - f7, 7201);
    check("vsync_line608",  vs_rise - f7, 7297);
    check("vsync_width",    vs_width, 96);

    // Reset mid-frame, then restart with NTSC horizontal ramp.
    pal = 1'b0; scandouble = 1'b0; pattern_sel = 2'd2;
    wait_out(8, 50, 5, 2000);
    reset = 1'b1;
    @(posedge clk);
    #1;
    a = cyc;
    step();
    check("mid_rst_ce",     ce_pix, 0);
    check("mid_rst_hblank", hblank, 0);
    check("mid_rst_hsync",  hsync, 0);
    check("mid_rst_vblank", vblank, 0);
    check("mid_rst_vsync",  vsync, 0);
    check("mid_rst_frame",  frame_cnt, 0);
    check("mid_rst_video",  video, 0);
    reset = 1'b0;
    wait_out(0, 0, HS_START, 100);
    check("restart_hs", hs_rise - a, 20);
    wait_out(0, 1, 2, 100);
`ifdef VTG_DITHER_EN
    check("dither_h2_range", video <= 8'd2, 1);
`else
    check("hramp_h2", video, 2);
`endif
    wait_out(0, 3, 0, 200);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
